// File: rtl/xrog_orbit_escalation.sv
//==============================================================================
// Module   : xrog_orbit_escalation
// Brief    : Persistence-filtered 5-state escalation FSM for XROG orbit
//            stability samples, emitting one valid/ready event per transition.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module xrog_orbit_escalation #(
  parameter int WARN_PERSIST    = 4,
  parameter int ALERT_PERSIST   = 2,
  parameter int RECOVER_PERSIST = 8,
  parameter int LOW_INDEX       = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [31:0] stability_index,
  input  logic        drift_warning,
  input  logic        instability_alert,
  input  logic [7:0]  orbit_type,
  output logic [2:0]  state,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [2:0]  evt_from_state,
  output logic [2:0]  evt_to_state,
  output logic [7:0]  evt_orbit_type,
  output logic [31:0] evt_min_index,
  output logic [15:0] evt_drop_cnt
);

  localparam logic [2:0] S_STABLE   = 3'd0;
  localparam logic [2:0] S_WATCH    = 3'd1;
  localparam logic [2:0] S_DEGRADED = 3'd2;
  localparam logic [2:0] S_CRITICAL = 3'd3;
  localparam logic [2:0] S_RECOVERY = 3'd4;

  localparam logic [31:0] IDX_MAX    = 32'd1000;
  localparam logic [31:0] LOW_IDX    = LOW_INDEX;
  localparam logic [7:0]  WARN_TH    = 8'(WARN_PERSIST);
  localparam logic [7:0]  ALERT_TH   = 8'(ALERT_PERSIST);
  localparam logic [7:0]  RECOVER_TH = 8'(RECOVER_PERSIST);

  logic [2:0]  state_q,   state_d;
  logic [7:0]  nok_q,     nok_d;
  logic [7:0]  alert_q,   alert_d;
  logic [7:0]  ok_q,      ok_d;
  logic [7:0]  orbit_q,   orbit_d;
  logic [31:0] min_q,     min_d;
  logic        evt_valid_q, evt_valid_d;
  logic [2:0]  evt_from_q,  evt_from_d;
  logic [2:0]  evt_to_q,    evt_to_d;
  logic [7:0]  evt_orbit_q, evt_orbit_d;
  logic [31:0] evt_min_q,   evt_min_d;
  logic [15:0] drop_q,      drop_d;

  logic [31:0] idx;
  logic [31:0] min_cur;
  logic        is_alert, is_ok;
  logic        orbit_change;
  logic [7:0]  nok_new, alert_new, ok_new;
  logic        transition;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Out-of-range indices come from upstream underflow and are worst-case.
  always_comb begin
    idx      = (stability_index > IDX_MAX) ? 32'd0 : stability_index;
    is_alert = instability_alert || (idx < LOW_IDX);
    is_ok    = !is_alert && !drift_warning;
    min_cur  = (idx < min_q) ? idx : min_q;
  end

  // Counts include the current sample; an orbit change restarts persistence.
  always_comb begin
    orbit_change = (orbit_type != orbit_q);
    nok_new   = is_ok    ? 8'd0 : sat_inc8(orbit_change ? 8'd0 : nok_q);
    alert_new = is_alert ? sat_inc8(orbit_change ? 8'd0 : alert_q) : 8'd0;
    ok_new    = is_ok    ? sat_inc8(orbit_change ? 8'd0 : ok_q) : 8'd0;
    nok_d     = nok_q;
    alert_d   = alert_q;
    ok_d      = ok_q;
    orbit_d   = orbit_q;
    if (sample_valid) begin
      nok_d   = nok_new;
      alert_d = alert_new;
      ok_d    = ok_new;
      orbit_d = orbit_type;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_STABLE;
      nok_q       <= 8'd0;
      alert_q     <= 8'd0;
      ok_q        <= 8'd0;
      orbit_q     <= 8'd0;
      min_q       <= IDX_MAX;
      evt_valid_q <= 1'b0;
      evt_from_q  <= 3'd0;
      evt_to_q    <= 3'd0;
      evt_orbit_q <= 8'd0;
      evt_min_q   <= 32'd0;
      drop_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      nok_q       <= nok_d;
      alert_q     <= alert_d;
      ok_q        <= ok_d;
      orbit_q     <= orbit_d;
      min_q       <= min_d;
      evt_valid_q <= evt_valid_d;
      evt_from_q  <= evt_from_d;
      evt_to_q    <= evt_to_d;
      evt_orbit_q <= evt_orbit_d;
      evt_min_q   <= evt_min_d;
      drop_q      <= drop_d;
    end
  end

  // Next-state logic; the alert rule is checked first wherever it applies.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_STABLE: begin
        if (sample_valid && !is_ok) state_d = S_WATCH;
      end
      S_WATCH: begin
        if (sample_valid) begin
          if (alert_new >= ALERT_TH)   state_d = S_CRITICAL;
          else if (nok_new >= WARN_TH) state_d = S_DEGRADED;
          else if (is_ok)              state_d = S_STABLE;
        end
      end
      S_DEGRADED: begin
        if (sample_valid) begin
          if (alert_new >= ALERT_TH)      state_d = S_CRITICAL;
          else if (ok_new >= RECOVER_TH)  state_d = S_STABLE;
        end
      end
      S_CRITICAL: begin
        if (sample_valid && is_ok) state_d = S_RECOVERY;
      end
      S_RECOVERY: begin
        if (sample_valid) begin
          if (!is_ok)                    state_d = S_CRITICAL;
          else if (ok_new >= RECOVER_TH) state_d = S_STABLE;
        end
      end
      default: state_d = S_STABLE;
    endcase
  end

  // Event and min-tracker logic; illegal-state recovery emits no event.
  always_comb begin
    transition  = sample_valid && (state_q <= S_RECOVERY) && (state_d != state_q);
    evt_valid_d = evt_valid_q;
    evt_from_d  = evt_from_q;
    evt_to_d    = evt_to_q;
    evt_orbit_d = evt_orbit_q;
    evt_min_d   = evt_min_q;
    drop_d      = drop_q;
    min_d       = sample_valid ? min_cur : min_q;
    if (transition) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_from_d  = state_q;
        evt_to_d    = state_d;
        evt_orbit_d = orbit_type;
        evt_min_d   = min_cur;
        min_d       = IDX_MAX;
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_comb begin
    state          = state_q;
    evt_valid      = evt_valid_q;
    evt_from_state = evt_from_q;
    evt_to_state   = evt_to_q;
    evt_orbit_type = evt_orbit_q;
    evt_min_index  = evt_min_q;
    evt_drop_cnt   = drop_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_xrog_orbit_escalation.sv
//==============================================================================
// Module   : tb_xrog_orbit_escalation
// Brief    : Directed stimulus with a queue-based event scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_xrog_orbit_escalation;

  typedef struct packed {
    logic [2:0]  from_s;
    logic [2:0]  to_s;
    logic [7:0]  orbit;
    logic [31:0] min_idx;
    logic [15:0] drop;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [31:0] stability_index = 32'd0;
  logic        drift_warning = 1'b0;
  logic        instability_alert = 1'b0;
  logic [7:0]  orbit_type = 8'd0;
  logic [2:0]  state;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [2:0]  evt_from_state;
  logic [2:0]  evt_to_state;
  logic [7:0]  evt_orbit_type;
  logic [31:0] evt_min_index;
  logic [15:0] evt_drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  evt_t exp_q[$];

  xrog_orbit_escalation dut (
    .clk               (clk),
    .rst               (rst),
    .sample_valid      (sample_valid),
    .stability_index   (stability_index),
    .drift_warning     (drift_warning),
    .instability_alert (instability_alert),
    .orbit_type        (orbit_type),
    .state             (state),
    .evt_valid         (evt_valid),
    .evt_ready         (evt_ready),
    .evt_from_state    (evt_from_state),
    .evt_to_state      (evt_to_state),
    .evt_orbit_type    (evt_orbit_type),
    .evt_min_index     (evt_min_index),
    .evt_drop_cnt      (evt_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] f, input logic [2:0] t, input logic [7:0] o,
                      input logic [31:0] m, input logic [15:0] d);
    evt_t e;
    e.from_s = f; e.to_s = t; e.orbit = o; e.min_idx = m; e.drop = d;
    exp_q.push_back(e);
  endtask

  // One sample per call, issued at posedge+1 and held across one edge.
  task automatic send(input logic [31:0] idx, input logic dw, input logic ia,
                      input logic [7:0] ot);
    stability_index   = idx;
    drift_warning     = dw;
    instability_alert = ia;
    orbit_type        = ot;
    sample_valid      = 1'b1;
    @(posedge clk); #1;
    sample_valid      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every handshake seen here completes at the following posedge.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL evt_unexpected: got %0d->%0d min %0d, expected none",
                 evt_from_state, evt_to_state, evt_min_index);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        chk("evt_from",  32'(evt_from_state), 32'(e.from_s));
        chk("evt_to",    32'(evt_to_state),   32'(e.to_s));
        chk("evt_orbit", 32'(evt_orbit_type), 32'(e.orbit));
        chk("evt_min",   evt_min_index,       e.min_idx);
        chk("evt_drop",  32'(evt_drop_cnt),   32'(e.drop));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_min",   evt_min_index, 0);
    chk("rst_drop",  32'(evt_drop_cnt), 0);

    // 1: single WARN, event held under backpressure
    send(800, 1, 0, 0); push(0, 1, 0, 800, 0);
    chk("s1_state", 32'(state), 1);
    idle(3);
    chk("s1_hold_valid", 32'(evt_valid), 1);
    chk("s1_hold_to",    32'(evt_to_state), 1);
    evt_ready = 1'b1;
    idle(2);
    chk("s1_released", 32'(evt_valid), 0);

    // 2: back to STABLE, then two ALERTs
    send(950, 0, 0, 0); push(1, 0, 0, 950, 0);
    chk("s2_stable", 32'(state), 0);
    send(250, 0, 0, 0); push(0, 1, 0, 250, 0);
    chk("s2_watch", 32'(state), 1);
    send(200, 0, 0, 0); push(1, 3, 0, 200, 0);
    chk("s2_critical", 32'(state), 3);

    // 3a: eight OKs recover fully
    send(950, 0, 0, 0); push(3, 4, 0, 950, 0);
    chk("s3_recovery", 32'(state), 4);
    for (int i = 0; i < 6; i++) send(950, 0, 0, 0);
    chk("s3_ok7", 32'(state), 4);
    send(950, 0, 0, 0); push(4, 0, 0, 950, 0);
    chk("s3_ok8", 32'(state), 0);

    // 3b: WARN at the fifth sample returns to CRITICAL
    send(100, 0, 0, 0); push(0, 1, 0, 100, 0);
    send(100, 0, 0, 0); push(1, 3, 0, 100, 0);
    send(950, 0, 0, 0); push(3, 4, 0, 950, 0);
    for (int i = 0; i < 3; i++) send(950, 0, 0, 0);
    chk("s3b_ok4", 32'(state), 4);
    send(950, 1, 0, 0); push(4, 3, 0, 950, 0);
    chk("s3b_warn", 32'(state), 3);
    idle(2);

    // 4: backpressure drops two, then accept+transition together
    evt_ready = 1'b0;
    send(950, 0, 0, 0); push(3, 4, 0, 950, 2);
    send(950, 1, 0, 0);
    send(950, 0, 0, 0);
    chk("s4_state",  32'(state), 4);
    chk("s4_from",   32'(evt_from_state), 3);
    chk("s4_to",     32'(evt_to_state), 4);
    chk("s4_min",    evt_min_index, 950);
    chk("s4_drop",   32'(evt_drop_cnt), 2);
    evt_ready = 1'b1;
    send(700, 1, 0, 0); push(4, 3, 0, 700, 2);
    chk("s4_valid_kept", 32'(evt_valid), 1);
    chk("s4_new_from",   32'(evt_from_state), 4);
    idle(2);

    // 5: underflowed index, orbit change restarts persistence
    send(950, 0, 0, 0); push(3, 4, 0, 950, 2);
    for (int i = 0; i < 6; i++) send(950, 0, 0, 0);
    send(950, 0, 0, 0); push(4, 0, 0, 950, 2);
    send(32'hFFFF_FF00, 0, 0, 0); push(0, 1, 0, 0, 2);
    chk("s5_watch", 32'(state), 1);
    send(800, 1, 0, 0);
    send(800, 1, 0, 0);
    send(800, 1, 0, 5);
    chk("s5_orbit_change", 32'(state), 1);
    send(800, 1, 0, 5);
    send(800, 1, 0, 5);
    chk("s5_nok3", 32'(state), 1);
    send(800, 1, 0, 5); push(1, 2, 5, 800, 2);
    chk("s5_degraded", 32'(state), 2);
    send(100, 0, 0, 5);
    chk("s5_alert1", 32'(state), 2);
    evt_ready = 1'b0;
    send(100, 0, 0, 5);
    chk("s5_critical", 32'(state), 3);
    chk("s5_pending",  32'(evt_valid), 1);

    // 6: reset with an event pending (that event is never accepted)
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("s6_state", 32'(state), 0);
    chk("s6_valid", 32'(evt_valid), 0);
    chk("s6_from",  32'(evt_from_state), 0);
    chk("s6_to",    32'(evt_to_state), 0);
    chk("s6_orbit", 32'(evt_orbit_type), 0);
    chk("s6_min",   evt_min_index, 0);
    chk("s6_drop",  32'(evt_drop_cnt), 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
